// File: rtl/data_align_pkg.sv
// data_align_pkg: shared defaults and config-derived helpers for data_align_pack
package data_align_pkg;
  localparam int DEF_GROUPS = 4;
  localparam int DW = 32;
  function automatic logic [3:0] popcount_zero(input logic [7:0] cfg, input int n);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k = k + {3'b0, ~cfg[i]};
    return k;
  endfunction
  // Samples per word: only whole samples are packed, otherwise one sample per word
  function automatic logic [3:0] pack_factor(input logic [3:0] k, input int n);
    return (k != 4'd0 && n % int'(k) == 0) ? 4'(n / int'(k)) : 4'd1;
  endfunction
endpackage

// File: rtl/data_align_pack_if.sv
// data_align_pack_if: sample input, flush request and packed-word output handshake
interface data_align_pack_if import data_align_pkg::*; #(
  parameter int NUM_GROUPS = DEF_GROUPS,
  parameter int GROUP_W = DW / DEF_GROUPS
);
  localparam int DATA_W = NUM_GROUPS * GROUP_W;
  localparam int FILL_W = $clog2(NUM_GROUPS) + 1;
  logic [NUM_GROUPS-1:0] disabledGroups;
  logic validIn;
  logic [DATA_W-1:0] dataIn;
  logic flush;
  logic readyOut;
  logic validOut;
  logic [DATA_W-1:0] dataOut;
  logic [FILL_W-1:0] dataOutFill;
  logic overflow;
  modport master (
    output disabledGroups, validIn, dataIn, flush, readyOut,
    input validOut, dataOut, dataOutFill, overflow
  );
  modport slave (
    input disabledGroups, validIn, dataIn, flush, readyOut,
    output validOut, dataOut, dataOutFill, overflow
  );
endinterface

// File: rtl/group_compact.sv
// group_compact: registers enabled groups packed onto the low lanes, upper lanes zeroed
module group_compact #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic [N-1:0] i_cfg,
  input  logic i_valid,
  input  logic i_drop,
  input  logic [N*W-1:0] i_data,
  output logic o_valid,
  output logic [N*W-1:0] o_lanes
);
  logic [N*W-1:0] w_lanes;
  logic r_valid;
  logic [N*W-1:0] r_lanes;
  always_comb begin
    int unsigned pos;
    pos = 0;
    w_lanes = '0;
    for (int i = 0; i < N; i++)
      if (!i_cfg[i]) begin
        w_lanes[pos*W +: W] = i_data[i*W +: W];
        pos = pos + 1;
      end
  end
  // With every group disabled there is nothing to carry forward
  always_ff @(posedge clock)
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_lanes <= '0;
    end else begin
      r_valid <= i_valid && !i_drop && !(&i_cfg);
      r_lanes <= w_lanes;
    end
  assign o_valid = r_valid;
  assign o_lanes = r_lanes;
endmodule

// File: rtl/data_align_pack.sv
// data_align_pack: compacts enabled groups per sample and packs samples into full-width words
module data_align_pack import data_align_pkg::*; #(
  parameter int NUM_GROUPS = DEF_GROUPS,
  parameter int GROUP_W = DW / DEF_GROUPS,
  parameter int FILL_W = $clog2(NUM_GROUPS) + 1
) (
  input logic clock,
  input logic reset_n,
  data_align_pack_if.slave bus
);
  localparam int DATA_W = NUM_GROUPS * GROUP_W;
  logic [NUM_GROUPS-1:0] r_cfg;
  logic [FILL_W-1:0] r_fill;
  logic [DATA_W-1:0] r_acc;
  logic r_vo;
  logic [DATA_W-1:0] r_do;
  logic [FILL_W-1:0] r_dof;
  logic r_ovf;
  logic w_chg, w_s1v, w_emit, w_load;
  logic [3:0] w_k;
  logic [FILL_W-1:0] w_p, w_fill_n;
  logic [DATA_W-1:0] w_lanes, w_acc_n;
  assign w_chg = bus.disabledGroups != r_cfg;
  assign w_k = popcount_zero(8'(r_cfg), NUM_GROUPS);
  assign w_p = FILL_W'(pack_factor(w_k, NUM_GROUPS));
  group_compact #(.N(NUM_GROUPS), .W(GROUP_W)) u_compact (
    .clock(clock), .reset_n(reset_n), .i_cfg(r_cfg), .i_valid(bus.validIn),
    .i_drop(w_chg), .i_data(bus.dataIn), .o_valid(w_s1v), .o_lanes(w_lanes)
  );
  assign w_fill_n = r_fill + FILL_W'(w_s1v);
  assign w_acc_n = r_acc | (w_s1v ? w_lanes << (32'(r_fill) * 32'(w_k) * GROUP_W) : '0);
  // A config change discards the partial word and overrides any flush
  assign w_emit = !w_chg && w_fill_n != '0 && ((w_s1v && w_fill_n == w_p) || bus.flush);
  assign w_load = w_emit && (!r_vo || bus.readyOut);
  always_ff @(posedge clock)
    if (!reset_n) begin
      r_cfg <= '1;
      r_fill <= '0;
      r_acc <= '0;
      r_vo <= 1'b0;
      r_do <= '0;
      r_dof <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cfg <= bus.disabledGroups;
      r_fill <= (w_chg || w_emit) ? '0 : w_fill_n;
      r_acc <= (w_chg || w_emit) ? '0 : w_acc_n;
      if (w_load) begin
        r_vo <= 1'b1;
        r_do <= w_acc_n;
        r_dof <= w_fill_n;
      end else if (bus.readyOut) r_vo <= 1'b0;
      if (w_emit && !w_load) r_ovf <= 1'b1;
    end
  assign bus.validOut = r_vo;
  assign bus.dataOut = r_do;
  assign bus.dataOutFill = r_dof;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_data_align_pack.sv
// tb_data_align_pack: directed and randomized checks against a queue-based packing model
module tb_data_align_pack;
  localparam int N = 4;
  localparam int W = 8;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [34:0] got[$];
  logic [3:0] m_cfg;
  logic m_s1v;
  logic [31:0] m_s1d;
  logic [31:0] m_q[$];
  logic m_vo, m_ovf;
  logic [31:0] m_do;
  int m_fo;
  data_align_pack_if #(.NUM_GROUPS(N), .GROUP_W(W)) bus ();
  data_align_pack #(.NUM_GROUPS(N), .GROUP_W(W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] compact(logic [31:0] d, logic [3:0] cfg);
    logic [31:0] r;
    int pos;
    r = 0;
    pos = 0;
    for (int i = 0; i < N; i++)
      if (!cfg[i]) begin
        r = r | (((d >> (i * W)) & 32'hFF) << (pos * W));
        pos++;
      end
    return r;
  endfunction
  task automatic model_step();
    int k, p;
    logic chg, held;
    logic [31:0] word;
    if (!reset_n) begin
      m_cfg = 4'hF; m_s1v = 0; m_s1d = 0; m_q.delete();
      m_vo = 0; m_do = 0; m_fo = 0; m_ovf = 0;
      return;
    end
    k = 0;
    for (int i = 0; i < N; i++) if (!m_cfg[i]) k++;
    p = (k > 0 && N % k == 0) ? N / k : 1;
    chg = bus.disabledGroups != m_cfg;
    held = m_vo && !bus.readyOut;
    if (m_vo && bus.readyOut) m_vo = 0;
    if (chg) m_q.delete();
    else begin
      if (m_s1v) m_q.push_back(m_s1d);
      if (m_q.size() != 0 && (m_q.size() == p || bus.flush)) begin
        word = 0;
        foreach (m_q[j]) word = word | (m_q[j] << (j * k * W));
        if (held) m_ovf = 1;
        else begin m_vo = 1; m_do = word; m_fo = m_q.size(); end
        m_q.delete();
      end
    end
    m_s1v = bus.validIn && !chg && k != 0;
    m_s1d = compact(bus.dataIn, m_cfg);
    m_cfg = bus.disabledGroups;
  endtask
  task automatic cyc();
    if (reset_n && bus.validOut && bus.readyOut) got.push_back({bus.dataOutFill, bus.dataOut});
    @(posedge clock);
    model_step();
    #1;
    check("validOut", bus.validOut, m_vo);
    if (m_vo) begin
      check("dataOut", bus.dataOut, m_do);
      check("dataOutFill", bus.dataOutFill, m_fo);
    end
    check("overflow", bus.overflow, m_ovf);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic sample(logic [31:0] d);
    bus.validIn = 1;
    bus.dataIn = d;
    cyc();
    bus.validIn = 0;
  endtask
  task automatic expect_word(string tag, logic [31:0] d, int f);
    logic [34:0] e;
    check({tag, "_present"}, got.size() != 0, 1);
    if (got.size() != 0) begin
      e = got.pop_front();
      check({tag, "_data"}, e[31:0], d);
      check({tag, "_fill"}, e[34:32], f);
    end
  endtask
  task automatic set_cfg(logic [3:0] c);
    bus.disabledGroups = c;
    idle(2);
    got.delete();
  endtask
  initial begin
    bus.disabledGroups = 4'hF; bus.validIn = 0; bus.dataIn = 0; bus.flush = 0; bus.readyOut = 1;
    idle(2);
    check("rst_validOut", bus.validOut, 0);
    check("rst_dataOut", bus.dataOut, 0);
    check("rst_fill", bus.dataOutFill, 0);
    check("rst_overflow", bus.overflow, 0);
    reset_n = 1;
    set_cfg(4'b0000);
    sample(32'hDDCCBBAA);
    check("lat_t1", bus.validOut, 0);
    sample(32'h44332211);
    check("lat_t2", bus.validOut, 1);
    idle(3);
    expect_word("pass0", 32'hDDCCBBAA, 1);
    expect_word("pass1", 32'h44332211, 1);
    set_cfg(4'b0111);
    sample(32'h11000000); sample(32'h22000000); sample(32'h33000000); sample(32'h44000000);
    idle(3);
    expect_word("k1", 32'h44332211, 4);
    set_cfg(4'b0101);
    sample(32'hAABBCCDD); sample(32'h11223344);
    idle(3);
    expect_word("k2", 32'h1133AACC, 2);
    set_cfg(4'b1110);
    sample(32'h0000005A); sample(32'h0000006B);
    bus.flush = 1; cyc(); bus.flush = 0;
    idle(3);
    expect_word("flush", 32'h00006B5A, 2);
    bus.flush = 1; cyc(); bus.flush = 0;
    idle(3);
    check("flush_empty", got.size(), 0);
    set_cfg(4'b0001);
    sample(32'h11223344);
    idle(3);
    expect_word("k3", 32'h00112233, 1);
    bus.disabledGroups = 4'b0011;
    sample(32'hDEADBEEF);
    sample(32'h55660000);
    idle(1);
    bus.flush = 1; cyc(); bus.flush = 0;
    idle(3);
    expect_word("chg", 32'h00005566, 1);
    check("chg_drop", got.size(), 0);
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 29) == 0) bus.disabledGroups = 4'($urandom_range(0, 15));
      bus.validIn = $urandom_range(0, 3) != 0;
      bus.dataIn = $urandom;
      bus.flush = $urandom_range(0, 7) == 0;
      bus.readyOut = $urandom_range(0, 3) != 0;
      reset_n = $urandom_range(0, 199) != 0;
      cyc();
    end
    bus.validIn = 0; bus.flush = 0; bus.readyOut = 1;
    reset_n = 0; idle(1); reset_n = 1;
    check("rst2_overflow", bus.overflow, 0);
    set_cfg(4'b0000);
    bus.readyOut = 0;
    sample(32'hA1A2A3A4); sample(32'hB1B2B3B4); sample(32'hC1C2C3C4);
    idle(2);
    check("bp_valid", bus.validOut, 1);
    check("bp_hold", bus.dataOut, 32'hA1A2A3A4);
    check("bp_overflow", bus.overflow, 1);
    bus.readyOut = 1;
    idle(3);
    expect_word("bp", 32'hA1A2A3A4, 1);
    check("bp_only", got.size(), 0);
    check("bp_sticky", bus.overflow, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
